// File: rtl/rv_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_muldiv_if
// Brief    : Request/response bundle between the EX stage and the iterative
//            RV32M/RV64M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface rv_muldiv_if #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 8
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] op;
  logic [XLEN-1:0]     a;
  logic [XLEN-1:0]     b;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     result;
  logic                illegal_op;

  // Pipeline side: issues operations and consumes results
  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, illegal_op
  );

  // Unit side
  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv_muldiv_unit
// Brief    : Iterative radix-2 M-extension unit (MUL/MULH/MULHSU/MULHU,
//            DIV/DIVU/REM/REMU). Shift-add multiply and restoring divide on
//            operand magnitudes, one step per cycle, sign applied at the end.
// Revision : 1.0 - initial release
// ============================================================================
module rv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rstN,
  rv_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int ACC_W = 2 * XLEN + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(8'h0C);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(8'h0D);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(8'h0E);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(8'h0F);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(8'h10);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(8'h11);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(8'h12);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(8'h13);

  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Architectural state
  logic [1:0]          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [OP_WIDTH-1:0] op_q,      op_d;
  logic [XLEN:0]       opnd_q,    opnd_d;     // multiplicand or divisor magnitude
  logic [ACC_W-1:0]    acc_q,     acc_d;      // {hi/remainder, lo/multiplier-or-quotient}
  logic                neg_q,     neg_d;      // final result must be negated
  logic [XLEN-1:0]     result_q,  result_d;
  logic                illegal_q, illegal_d;

  // Request decode
  logic            w_is_mul, w_is_div, w_is_rem, w_sgn_a, w_sgn_b;
  logic            w_neg_a, w_neg_b, w_div_zero, w_ovf;
  logic [XLEN:0]   w_mag_a, w_mag_b;

  // Iteration datapath
  logic [XLEN:0]     w_mul_sum;
  logic [ACC_W-1:0]  w_mul_next;
  logic [XLEN:0]     w_div_trial, w_div_diff;
  logic              w_div_ge;
  logic [ACC_W-1:0]  w_div_next;
  logic              w_op_mul_q;
  logic [ACC_W-1:0]  w_step;

  // Result formatting
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_div_res, w_div_s, w_final;

  // Classify the incoming op and which operands are treated as signed
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_is_rem = 1'b0;
    w_sgn_a  = 1'b0;
    w_sgn_b  = 1'b0;
    case (bus.op)
      OP_MUL, OP_MULH: begin
        w_is_mul = 1'b1;
        w_sgn_a  = 1'b1;
        w_sgn_b  = 1'b1;
      end
      OP_MULHSU: begin
        w_is_mul = 1'b1;
        w_sgn_a  = 1'b1;
      end
      OP_MULHU: w_is_mul = 1'b1;
      OP_DIV: begin
        w_is_div = 1'b1;
        w_sgn_a  = 1'b1;
        w_sgn_b  = 1'b1;
      end
      OP_DIVU: w_is_div = 1'b1;
      OP_REM: begin
        w_is_div = 1'b1;
        w_is_rem = 1'b1;
        w_sgn_a  = 1'b1;
        w_sgn_b  = 1'b1;
      end
      OP_REMU: begin
        w_is_div = 1'b1;
        w_is_rem = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_neg_a = w_sgn_a & bus.a[XLEN-1];
  assign w_neg_b = w_sgn_b & bus.b[XLEN-1];

  // One extra bit so the magnitude of MIN_INT is representable
  assign w_mag_a = w_neg_a ? ({1'b0, ~bus.a} + (XLEN+1)'(1)) : {1'b0, bus.a};
  assign w_mag_b = w_neg_b ? ({1'b0, ~bus.b} + (XLEN+1)'(1)) : {1'b0, bus.b};

  assign w_div_zero = w_is_div && (bus.b == '0);
  assign w_ovf      = w_is_div && w_sgn_a && (bus.a == MIN_INT) && (bus.b == ALL_ONES);

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set
  assign w_mul_sum  = acc_q[ACC_W-1:XLEN] + (acc_q[0] ? opnd_q : '0);
  assign w_mul_next = {1'b0, w_mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: shift in next dividend bit, subtract divisor when it fits
  assign w_div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_div_ge    = (w_div_trial >= opnd_q);
  assign w_div_diff  = w_div_trial - opnd_q;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_trial), acc_q[XLEN-2:0], w_div_ge};

  // Only legal ops are latched, and all multiplies encode below DIV
  assign w_op_mul_q = (op_q < OP_DIV);
  assign w_step     = w_op_mul_q ? w_mul_next : w_div_next;

  // Sign correction and half selection applied to the last iteration's value
  assign w_prod    = w_step[2*XLEN-1:0];
  assign w_prod_s  = neg_q ? -w_prod : w_prod;
  assign w_div_res = ((op_q == OP_REM) || (op_q == OP_REMU)) ? w_step[2*XLEN-1:XLEN]
                                                             : w_step[XLEN-1:0];
  assign w_div_s   = neg_q ? -w_div_res : w_div_res;
  assign w_final   = w_op_mul_q ? ((op_q == OP_MUL) ? w_prod_s[XLEN-1:0]
                                                    : w_prod_s[2*XLEN-1:XLEN])
                                : w_div_s;

  // Next-state logic for the IDLE -> CALC -> DONE sequencer; flush overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (!(w_is_mul || w_is_div)) begin
            illegal_d = 1'b1;
          end else begin
            op_d  = bus.op;
            cnt_d = '0;
            neg_d = w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
            if (w_is_mul) begin
              opnd_d = w_mag_a;
              acc_d  = {{(XLEN+1){1'b0}}, w_mag_b[XLEN-1:0]};
            end else begin
              opnd_d = w_mag_b;
              acc_d  = {{(XLEN+1){1'b0}}, w_mag_a[XLEN-1:0]};
            end
            if (w_div_zero) begin
              result_d = w_is_rem ? bus.a : ALL_ONES;
              state_d  = S_DONE;
            end else if (w_ovf) begin
              result_d = w_is_rem ? '0 : MIN_INT;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end
        end
      end
      S_CALC: begin
        acc_d = w_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = w_final;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.result     = result_q;
  assign bus.illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_muldiv_unit
// Brief    : Self-checking bench for rv_muldiv_unit (XLEN=32 and XLEN=64).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv_muldiv_unit;

  localparam logic [7:0] OP_MUL    = 8'h0C;
  localparam logic [7:0] OP_MULH   = 8'h0D;
  localparam logic [7:0] OP_MULHSU = 8'h0E;
  localparam logic [7:0] OP_MULHU  = 8'h0F;
  localparam logic [7:0] OP_DIV    = 8'h10;
  localparam logic [7:0] OP_DIVU   = 8'h11;
  localparam logic [7:0] OP_REM    = 8'h12;
  localparam logic [7:0] OP_REMU   = 8'h13;

  logic        clk = 1'b0;
  logic        rstN, flush, vld, ordy, sel64;
  logic [7:0]  op_drv;
  logic [63:0] a_drv, b_drv;

  always #5 clk = ~clk;

  rv_muldiv_if #(.XLEN(32), .OP_WIDTH(8)) if32 ();
  rv_muldiv_if #(.XLEN(64), .OP_WIDTH(8)) if64 ();

  assign if32.flush     = flush;
  assign if32.in_valid  = vld & ~sel64;
  assign if32.op        = op_drv;
  assign if32.a         = a_drv[31:0];
  assign if32.b         = b_drv[31:0];
  assign if32.out_ready = ordy & ~sel64;
  assign if64.flush     = flush;
  assign if64.in_valid  = vld & sel64;
  assign if64.op        = op_drv;
  assign if64.a         = a_drv;
  assign if64.b         = b_drv;
  assign if64.out_ready = ordy & sel64;

  rv_muldiv_unit #(.XLEN(32), .OP_WIDTH(8)) dut32 (.clk(clk), .rstN(rstN), .bus(if32));
  rv_muldiv_unit #(.XLEN(64), .OP_WIDTH(8)) dut64 (.clk(clk), .rstN(rstN), .bus(if64));

  logic        w_rdy, w_ov, w_ill;
  logic [63:0] w_res;
  assign w_rdy = sel64 ? if64.in_ready   : if32.in_ready;
  assign w_ov  = sel64 ? if64.out_valid  : if32.out_valid;
  assign w_ill = sel64 ? if64.illegal_op : if32.illegal_op;
  assign w_res = sel64 ? if64.result     : {32'd0, if32.result};

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic reference using wide signed operators
  function automatic logic [63:0] golden(input int xl, input logic [7:0] op,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, ua, ub, p;
    logic [63:0] mask;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    ua = $signed({66'd0, a & mask});
    ub = $signed({66'd0, b & mask});
    if (xl == 32) begin
      sa = $signed({{98{a[31]}}, a[31:0]});
      sb = $signed({{98{b[31]}}, b[31:0]});
    end else begin
      sa = $signed({{66{a[63]}}, a});
      sb = $signed({{66{b[63]}}, b});
    end
    p = '0;
    case (op)
      OP_MUL, OP_MULH: p = sa * sb;
      OP_MULHSU:       p = sa * ub;
      OP_MULHU:        p = ua * ub;
      OP_DIV:  if (ub == 0) p = -130'sd1; else p = sa / sb;
      OP_DIVU: if (ub == 0) p = -130'sd1; else p = ua / ub;
      OP_REM:  if (ub == 0) p = sa;       else p = sa % sb;
      OP_REMU: if (ub == 0) p = ua;       else p = ua % ub;
      default: p = '0;
    endcase
    if (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU) p = p >> xl;
    return p[63:0] & mask;
  endfunction

  function automatic int lat_model(input int xl, input logic [7:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    minv = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
    if (op >= OP_DIV && (b & mask) == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && (a & mask) == minv && (b & mask) == mask) return 1;
    return xl + 1;
  endfunction

  function automatic logic [63:0] pick(input int xl);
    logic [63:0] v;
    int s;
    s = $urandom_range(0, 7);
    v = {$urandom, $urandom};
    case (s)
      0: v = '0;
      1: v = '1;
      2: v = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(1, 20));
      default: ;
    endcase
    if (xl == 32) v = {32'd0, v[31:0]};
    return v;
  endfunction

  // Issue one op, check latency and result; optionally stall the consumer for 'hold' cycles
  task automatic run_op(input string name, input logic s64, input logic [7:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int exp_lat, input int hold);
    int lat;
    logic [63:0] e;
    sel64 = s64;
    lat = 0;
    while (!w_rdy && lat < 200) begin
      tick();
      lat++;
    end
    chk({name, " in_ready"}, 64'(w_rdy), 64'd1);
    op_drv = op;
    a_drv  = a;
    b_drv  = b;
    vld    = 1'b1;
    exp_q.push_back(exp);
    tick();
    vld   = 1'b0;
    a_drv = {$urandom, $urandom};
    b_drv = {$urandom, $urandom};
    lat = 1;
    while (!w_ov && lat < 200) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    if (!w_ov) begin
      chk({name, " out_valid timeout"}, 64'(w_ov), 64'd1);
    end else begin
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " result"}, w_res, e);
      for (int k = 0; k < hold; k++) begin
        vld    = 1'b1;
        op_drv = OP_DIV;
        a_drv  = 64'd9;
        b_drv  = 64'd0;
        chk({name, " hold out_valid"}, 64'(w_ov), 64'd1);
        chk({name, " hold result"}, w_res, e);
        chk({name, " hold in_ready"}, 64'(w_rdy), 64'd0);
        tick();
      end
      vld  = 1'b0;
      ordy = 1'b1;
      tick();
      ordy = 1'b0;
      chk({name, " idle in_ready"}, 64'(w_rdy), 64'd1);
      chk({name, " idle out_valid"}, 64'(w_ov), 64'd0);
    end
  endtask

  initial begin
    int nov;
    logic [7:0]  rop;
    logic [63:0] ra, rb;

    vt[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd33};
    vt[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 8'd33};
    vt[2]  = '{OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 8'd33};
    vt[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd33};
    vt[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 8'd33};
    vt[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 8'd33};
    vt[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        8'd33};
    vt[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         8'd33};
    vt[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1};
    vt[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         8'd1};
    vt[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
    vt[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         8'd1};
    vt[12] = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1};
    vt[13] = '{OP_REMU,   32'd5,          32'd0,         32'd5,         8'd1};
    vt[14] = '{OP_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 8'd33};
    vt[15] = '{OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         8'd33};
    vt[16] = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33};
    vt[17] = '{OP_REMU,   32'hFFFF_FFFF,  32'd16,        32'd15,        8'd33};

    rstN = 1'b0; flush = 1'b0; vld = 1'b0; ordy = 1'b0; sel64 = 1'b0;
    op_drv = '0; a_drv = '0; b_drv = '0;
    repeat (3) tick();
    chk("reset in_ready32",  64'(if32.in_ready),   64'd1);
    chk("reset out_valid32", 64'(if32.out_valid),  64'd0);
    chk("reset result32",    64'(if32.result),     64'd0);
    chk("reset illegal32",   64'(if32.illegal_op), 64'd0);
    chk("reset in_ready64",  64'(if64.in_ready),   64'd1);
    chk("reset out_valid64", 64'(if64.out_valid),  64'd0);
    rstN = 1'b1;
    tick();

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), 1'b0, vt[i].op, {32'd0, vt[i].a}, {32'd0, vt[i].b},
             {32'd0, vt[i].exp}, int'(vt[i].lat), 0);

    // Consumer backpressure while DONE, with new requests presented and ignored
    run_op("backpressure", 1'b0, OP_MUL, 64'd6, 64'd7, 64'd42, 33, 10);

    // Illegal op: single-cycle pulse, no result
    sel64 = 1'b0; op_drv = 8'h05; a_drv = 64'd1; b_drv = 64'd1; vld = 1'b1;
    tick();
    vld = 1'b0;
    chk("illegal pulse",     64'(w_ill), 64'd1);
    chk("illegal out_valid", 64'(w_ov),  64'd0);
    chk("illegal in_ready",  64'(w_rdy), 64'd1);
    tick();
    chk("illegal pulse end", 64'(w_ill), 64'd0);
    nov = 0;
    for (int k = 0; k < 40; k++) begin
      if (w_ov) nov++;
      tick();
    end
    chk("illegal no result", 64'(nov), 64'd0);

    // Flush while the counter holds 10
    op_drv = OP_MUL; a_drv = 64'd123; b_drv = 64'd456; vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in_ready",  64'(w_rdy), 64'd1);
    chk("flush out_valid", 64'(w_ov),  64'd0);
    nov = 0;
    for (int k = 0; k < 40; k++) begin
      if (w_ov) nov++;
      tick();
    end
    chk("flush no result", 64'(nov), 64'd0);
    run_op("post-flush mul", 1'b0, OP_MUL, 64'd3, 64'd4, 64'd12, 33, 0);

    // Reset in the middle of a divide clears the held result too
    op_drv = OP_DIV; a_drv = 64'd1000; b_drv = 64'd3; vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (5) tick();
    rstN = 1'b0;
    tick();
    chk("midreset in_ready",  64'(if32.in_ready),   64'd1);
    chk("midreset out_valid", 64'(if32.out_valid),  64'd0);
    chk("midreset result",    64'(if32.result),     64'd0);
    chk("midreset illegal",   64'(if32.illegal_op), 64'd0);
    rstN = 1'b1;
    tick();

    // Random operations against the reference, both widths
    for (int i = 0; i < 40; i++) begin
      rop = OP_MUL + 8'($urandom_range(0, 7));
      ra  = pick(32);
      rb  = pick(32);
      run_op($sformatf("rand32_%0d op%h", i, rop), 1'b0, rop, ra, rb,
             golden(32, rop, ra, rb), lat_model(32, rop, ra, rb), 0);
    end
    for (int i = 0; i < 20; i++) begin
      rop = OP_MUL + 8'($urandom_range(0, 7));
      ra  = pick(64);
      rb  = pick(64);
      run_op($sformatf("rand64_%0d op%h", i, rop), 1'b1, rop, ra, rb,
             golden(64, rop, ra, rb), lat_model(64, rop, ra, rb), 0);
    end
    run_op("rand64 minint div", 1'b1, OP_DIV, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
